dq_rx_align: RTL
================

# dq_rx_align

Read-path stage directly downstream of the DQ pin SERDES instances. Each cycle it takes the 8 deserialized samples from every DQ lane, trains a per-lane bit offset against a known pattern, and applies it to realign the serial stream. It then transposes lane samples into bus bytes and delivers a counted read burst as 64-bit words to the controller. Bit 0 of each lane word is the earliest sample, matching the transmit ordering.

## Interface
Parameters:
- `LANES`, 8, DQ lanes (bus width); the transpose yields 8 bytes per cycle.
- `TRAIN_PATTERN`, 8'hA5, per-lane serial training word; all 8 rotations distinct.
- `MATCH_COUNT`, 4, consecutive matching cycles required to lock a lane.
- `TIMEOUT`, 1024, SEARCH cycles before FAIL.
- `LEN_W`, 16, width of the burst word count.

Ports:
- `clk_div_in`  in  1  one clock, the SERDES parallel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_samples`  in  LANES*8  lane i at [8i+7:8i], from the SERDES `data_to_fabric`.
- `train_start`  in  1  pulse; begin offset search.
- `rd_start`  in  1  pulse; first wanted samples are on `rx_samples` this cycle.
- `rd_words`  in  LEN_W  burst length in 64-bit words, sampled with `rd_start`.
- `rx_data`  out  LANES*8  byte k at [8k+7:8k]; byte k = {lane7[k],…,lane0[k]}.
- `rx_valid`  out  1  `rx_data` holds a burst word.
- `rd_done`  out  1  one-cycle pulse at burst end.
- `locked`  out  1  all lanes trained.
- `train_fail`  out  1  last training timed out.
- `lane_offset`  out  LANES*3  current offset per lane.

## Operation
- Window: per lane W = {cur, prev}. `prev` is the previous cycle's lane word. Offset o selects W[o+7:o].
- FSM states: IDLE, SEARCH, LOCKED, READ, FAIL.
- IDLE/LOCKED/FAIL + `train_start` → SEARCH:
  - clear per-lane lock flags, match counters and the timeout counter;
  - clear `locked` and `train_fail`.
- SEARCH, each unlocked lane, each cycle:
  - candidate = lowest o whose window equals `TRAIN_PATTERN`;
  - same candidate as last cycle → count+1, otherwise count=1; no match → count=0;
  - count reaching `MATCH_COUNT` latches the offset and locks the lane;
  - locked lanes freeze.
- SEARCH exits:
  - all lanes locked → LOCKED with `locked`=1;
  - timeout counter reaching `TIMEOUT` → FAIL with `train_fail`=1. Already-locked lanes keep their offsets; unlocked lanes keep their previous offsets.
- LOCKED + `rd_start`:
  - `rd_words`=0 → `rd_done` next cycle, no `rx_valid`, stay LOCKED;
  - otherwise → READ, word counter loads `rd_words`.
- READ:
  - each cycle emits one word, decrementing the counter;
  - the last word asserts `rx_valid` and `rd_done` together, then returns to LOCKED.
- Ignored inputs:
  - `rd_start` outside LOCKED;
  - `train_start` in SEARCH or READ.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rd_done`=0, `locked`=0, `train_fail`=0, `lane_offset`=0, `prev`=0, FSM=IDLE.
- Latency: samples presented at cycle t (with cycle t−1 as `prev`) appear on `rx_data` at t+1 (one register).
- The first burst word corresponds to the `rd_start` cycle's samples. `rx_valid` runs contiguously for exactly `rd_words` cycles, with no backpressure.
- Outside READ, `rx_data` updates every cycle with `rx_valid`=0.
- Minimum SEARCH to LOCKED: `MATCH_COUNT` cycles after the first matching cycle.
- The timeout counter saturates at `TIMEOUT`.
- Offsets change only in SEARCH, never during READ.
- `reset_n` asserted mid-burst aborts without `rd_done`; all outputs take their reset values.

## Structure
- Package `dq_rx_pkg` holds:
  - state enum `dq_rx_state_t`;
  - `DQ_LANES`=8;
  - default `TRAIN_PATTERN`;
  - localparam `OFF_W`=3.
- Sub-module `dq_lane_align`, one instance per lane, holds:
  - `prev` register and 8-way window mux;
  - 8-way pattern compare and lowest-match encoder;
  - match counter, lock flag and offset register.
- Top level holds the FSM, timeout and word counters, the transpose and the output register.

## Test plan
- Lane 0 stream pre-shifted by 3 bits and all other lanes by 0, `train_start` → `lane_offset`[2:0]=3, others 0. `locked`=1 after 4 matching cycles.
- Random non-pattern data in SEARCH → `train_fail`=1 after 1024 cycles, `locked`=0, FSM FAIL. A later `train_start` with a clean pattern locks.
- LOCKED, `rd_start` with `rd_words`=3 and lane words giving bytes 0x00..0x17:
  - `rx_valid` on 3 consecutive cycles starting one after `rd_start`, carrying 0x0706…00, 0x0F0E…08, 0x1716…10;
  - `rd_done` with the third word.
- `rd_words`=0 → `rd_done` single pulse, `rx_valid` never high. Likewise `rd_start` in IDLE → no response.
- `reset_n` low on the second of 5 burst words → all outputs 0 immediately, no `rd_done`. After release, `locked`=0 and FSM IDLE.
- `train_start` during READ → burst completes unaffected and offsets unchanged.

Source files
------------

// File: rtl/dq_rx_pkg.sv
// Shared types and constants for the DQ read-path alignment stage.
package dq_rx_pkg;

    localparam int unsigned DQ_LANES              = 8;
    localparam int unsigned OFF_W                 = 3;
    localparam logic [7:0]  TRAIN_PATTERN_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_LOCKED,
        ST_READ,
        ST_FAIL
    } dq_rx_state_t;

endpackage

// File: rtl/dq_lane_align.sv
// Per-lane bit aligner: previous-word window, pattern search, match counting
// and the trained offset that realigns the lane's serial stream.
module dq_lane_align
    import dq_rx_pkg::*;
#(
    parameter logic [7:0]  TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT,
    parameter int unsigned MATCH_COUNT   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       lane_in,
    input  logic             search,
    input  logic             clear,
    output logic [7:0]       aligned,
    output logic             lock_next,
    output logic [OFF_W-1:0] offset
);

    localparam int unsigned CNT_W = $clog2(MATCH_COUNT + 1);

    logic [7:0]       prev;
    logic [15:0]      window;
    logic             hit_any;
    logic [OFF_W-1:0] cand;
    logic [OFF_W-1:0] last_cand;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] match_cnt_nxt;
    logic             lane_locked;
    logic             lock_now;

    // Bit 0 is the earliest sample, so the older word sits in the low half.
    assign window  = {lane_in, prev};
    assign aligned = window[{1'b0, offset} +: 8];

    always_comb begin
        hit_any = 1'b0;
        cand    = '0;
        for (int unsigned o = 0; o < 8; o++) begin
            if (!hit_any && window[o +: 8] == TRAIN_PATTERN) begin
                hit_any = 1'b1;
                cand    = OFF_W'(o);
            end
        end
    end

    always_comb begin
        if (!hit_any)
            match_cnt_nxt = '0;
        else if (match_cnt != '0 && cand == last_cand)
            match_cnt_nxt = match_cnt + 1'b1;
        else
            match_cnt_nxt = CNT_W'(1);
    end

    assign lock_now  = search && !lane_locked && (match_cnt_nxt == CNT_W'(MATCH_COUNT));
    assign lock_next = lane_locked || lock_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev        <= '0;
            match_cnt   <= '0;
            last_cand   <= '0;
            lane_locked <= 1'b0;
            offset      <= '0;
        end else begin
            prev <= lane_in;
            if (clear) begin
                match_cnt   <= '0;
                lane_locked <= 1'b0;
            end else if (search && !lane_locked) begin
                match_cnt <= match_cnt_nxt;
                last_cand <= cand;
                if (lock_now) begin
                    lane_locked <= 1'b1;
                    offset      <= cand;
                end
            end
        end
    end

endmodule

// File: rtl/dq_rx_align.sv
// DQ read-path aligner: trains per-lane offsets, transposes lanes into bus
// bytes and delivers counted read bursts as full-width words.
module dq_rx_align
    import dq_rx_pkg::*;
#(
    parameter int unsigned LANES         = DQ_LANES,
    parameter logic [7:0]  TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT,
    parameter int unsigned MATCH_COUNT   = 4,
    parameter int unsigned TIMEOUT       = 1024,
    parameter int unsigned LEN_W         = 16
) (
    input  logic                   clk_div_in,
    input  logic                   reset_n,
    input  logic [LANES*8-1:0]     rx_samples,
    input  logic                   train_start,
    input  logic                   rd_start,
    input  logic [LEN_W-1:0]       rd_words,
    output logic [LANES*8-1:0]     rx_data,
    output logic                   rx_valid,
    output logic                   rd_done,
    output logic                   locked,
    output logic                   train_fail,
    output logic [LANES*OFF_W-1:0] lane_offset
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    dq_rx_state_t       state;
    dq_rx_state_t       state_nxt;
    logic [LANES*8-1:0] aligned;
    logic [LANES*8-1:0] bus_word;
    logic [LANES-1:0]   lock_next;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [LEN_W-1:0]   words_left;
    logic               search;
    logic               train_go;
    logic               rd_go;
    logic               all_lock;
    logic               tmo_hit;
    logic               valid_nxt;
    logic               done_nxt;
    logic               locked_nxt;
    logic               fail_nxt;

    assign search   = (state == ST_SEARCH);
    assign train_go = train_start && (state == ST_IDLE || state == ST_LOCKED || state == ST_FAIL);
    assign rd_go    = rd_start && !train_start && (state == ST_LOCKED);
    assign all_lock = &lock_next;
    assign tmo_hit  = search && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dq_lane_align #(
            .TRAIN_PATTERN (TRAIN_PATTERN),
            .MATCH_COUNT   (MATCH_COUNT)
        ) u_lane (
            .clk       (clk_div_in),
            .rst_n     (reset_n),
            .lane_in   (rx_samples[i*8 +: 8]),
            .search    (search),
            .clear     (train_go),
            .aligned   (aligned[i*8 +: 8]),
            .lock_next (lock_next[i]),
            .offset    (lane_offset[i*OFF_W +: OFF_W])
        );
    end

    always_comb begin
        bus_word = '0;
        for (int unsigned k = 0; k < 8; k++)
            for (int unsigned i = 0; i < LANES; i++)
                bus_word[k*LANES + i] = aligned[i*8 + k];
    end

    always_ff @(posedge clk_div_in or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // The rd_start cycle already captures the first word, so READ only
    // covers the remaining rd_words-1 cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_FAIL: if (train_go) state_nxt = ST_SEARCH;
            ST_LOCKED: begin
                if (train_go)
                    state_nxt = ST_SEARCH;
                else if (rd_go && rd_words > LEN_W'(1))
                    state_nxt = ST_READ;
            end
            ST_SEARCH: begin
                if (all_lock)     state_nxt = ST_LOCKED;
                else if (tmo_hit) state_nxt = ST_FAIL;
            end
            ST_READ: if (words_left == LEN_W'(1)) state_nxt = ST_LOCKED;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_nxt  = 1'b0;
        done_nxt   = 1'b0;
        locked_nxt = locked;
        fail_nxt   = train_fail;
        case (state)
            ST_SEARCH: begin
                if (all_lock)     locked_nxt = 1'b1;
                else if (tmo_hit) fail_nxt   = 1'b1;
            end
            ST_LOCKED: begin
                if (rd_go) begin
                    valid_nxt = (rd_words != '0);
                    done_nxt  = (rd_words == '0) || (rd_words == LEN_W'(1));
                end
            end
            ST_READ: begin
                valid_nxt = 1'b1;
                done_nxt  = (words_left == LEN_W'(1));
            end
            default: ;
        endcase
        if (train_go) begin
            locked_nxt = 1'b0;
            fail_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk_div_in or negedge reset_n) begin
        if (!reset_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rd_done    <= 1'b0;
            locked     <= 1'b0;
            train_fail <= 1'b0;
            tmo_cnt    <= '0;
            words_left <= '0;
        end else begin
            rx_data    <= bus_word;
            rx_valid   <= valid_nxt;
            rd_done    <= done_nxt;
            locked     <= locked_nxt;
            train_fail <= fail_nxt;
            if (train_go)
                tmo_cnt <= '0;
            else if (search && tmo_cnt != TMO_W'(TIMEOUT))
                tmo_cnt <= tmo_cnt + 1'b1;
            if (rd_go)
                words_left <= rd_words - 1'b1;
            else if (state == ST_READ)
                words_left <= words_left - 1'b1;
        end
    end

endmodule
